// File: rtl/operand_cmp_seq.sv
// operand_cmp_seq: registered operand comparator with a consecutive-hit
// run counter and a one-cycle done pulse after HOLD hits in a row.
// Optional build macro: CMP_SIGNED_EN makes LT/GT compare as two's complement.
module operand_cmp_seq #(
   parameter int WIDTH = 16,
   parameter int HOLD  = 4,
   localparam int CNT_W = $clog2(HOLD + 1)
) (
   input  logic             clk_i,
   input  logic             rst_i,
   input  logic             in_valid_i,
   input  logic [WIDTH-1:0] in_data_i,
   input  logic [WIDTH-1:0] ref_data_i,
   input  logic [1:0]       mode_i,
   input  logic             clr_i,
   output logic             out_valid_o,
   output logic             zer_o,
   output logic             hit_o,
   output logic [CNT_W-1:0] run_cnt_o,
   output logic             done_o
);

   localparam logic [CNT_W-1:0] HOLD_C = CNT_W'(HOLD);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      LOCK = 2'd2
   } state_t;

   state_t           state_q;
   logic             out_valid_q, zer_q, hit_q, done_q;
   logic [CNT_W-1:0] cnt_q;
   logic [CNT_W-1:0] cnt_inc;
   logic             zer_d, hit_d, lt_d, gt_d;

   // Current-sample compare results; only the magnitude compares change with the build.
   always_comb begin
      zer_d = (in_data_i == '0);
`ifdef CMP_SIGNED_EN
      lt_d  = ($signed(in_data_i) < $signed(ref_data_i));
      gt_d  = ($signed(in_data_i) > $signed(ref_data_i));
`else
      lt_d  = (in_data_i < ref_data_i);
      gt_d  = (in_data_i > ref_data_i);
`endif
      case (mode_i)
         2'b00:   hit_d = (in_data_i == ref_data_i);
         2'b01:   hit_d = lt_d;
         2'b10:   hit_d = gt_d;
         default: hit_d = zer_d;
      endcase
   end

   assign cnt_inc = cnt_q + CNT_W'(1);

   // Output registers and run-tracking FSM; done is a single-cycle pulse on entry to LOCK.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q     <= IDLE;
         out_valid_q <= 1'b0;
         zer_q       <= 1'b0;
         hit_q       <= 1'b0;
         cnt_q       <= '0;
         done_q      <= 1'b0;
      end else begin
         out_valid_q <= in_valid_i;
         done_q      <= 1'b0;
         if (in_valid_i) begin
            zer_q <= zer_d;
            hit_q <= hit_d;
         end
         if (clr_i) begin
            // clr still lets the sample through to zer/hit, but never counts it
            cnt_q   <= '0;
            state_q <= IDLE;
         end else if (in_valid_i) begin
            if (!hit_d) begin
               cnt_q   <= '0;
               state_q <= IDLE;
            end else begin
               case (state_q)
                  LOCK: begin
                     cnt_q   <= HOLD_C;
                     state_q <= LOCK;
                  end
                  default: begin
                     cnt_q <= cnt_inc;
                     if (cnt_inc == HOLD_C) begin
                        state_q <= LOCK;
                        done_q  <= 1'b1;
                     end else begin
                        state_q <= RUN;
                     end
                  end
               endcase
            end
         end
      end
   end

   assign out_valid_o = out_valid_q;
   assign zer_o       = zer_q;
   assign hit_o       = hit_q;
   assign run_cnt_o   = cnt_q;
   assign done_o      = done_q;

endmodule

// File: tb/tb_operand_cmp_seq.sv
// Directed bench for operand_cmp_seq (WIDTH=16, HOLD=4).
module tb_operand_cmp_seq;

   logic        clk = 1'b0;
   logic        rst, in_valid, clr;
   logic [15:0] in_data, ref_data;
   logic [1:0]  mode;
   logic        out_valid, zer, hit, done;
   logic [2:0]  run_cnt;

   int n_tests = 0;
   int n_fail  = 0;

   operand_cmp_seq #(.WIDTH(16), .HOLD(4)) dut (
      .clk_i       (clk),
      .rst_i       (rst),
      .in_valid_i  (in_valid),
      .in_data_i   (in_data),
      .ref_data_i  (ref_data),
      .mode_i      (mode),
      .clr_i       (clr),
      .out_valid_o (out_valid),
      .zer_o       (zer),
      .hit_o       (hit),
      .run_cnt_o   (run_cnt),
      .done_o      (done)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic chk_all(input string tag, input logic ov, input logic z, input logic h,
                          input logic [2:0] c, input logic d);
      chk({tag, ".out_valid"}, 32'(out_valid), 32'(ov));
      chk({tag, ".zer"},       32'(zer),       32'(z));
      chk({tag, ".hit"},       32'(hit),       32'(h));
      chk({tag, ".run_cnt"},   32'(run_cnt),   32'(c));
      chk({tag, ".done"},      32'(done),      32'(d));
   endtask

   // Apply one cycle of inputs, then sample 1 time unit after the edge.
   task automatic step(input logic r, input logic v, input logic [15:0] d,
                       input logic [15:0] rf, input logic [1:0] m, input logic c);
      rst = r; in_valid = v; in_data = d; ref_data = rf; mode = m; clr = c;
      @(posedge clk);
      #1;
   endtask

   logic       sgn;
   logic [2:0] exp_cnt [6];
   logic       exp_dn  [6];

   initial begin
`ifdef CMP_SIGNED_EN
      sgn = 1'b1;
`else
      sgn = 1'b0;
`endif
      exp_cnt = '{3'd1, 3'd2, 3'd3, 3'd4, 3'd4, 3'd4};
      exp_dn  = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};

      // reset for 2 cycles, then an idle cycle
      step(1, 0, 16'h0, 16'h0, 2'b00, 0);
      step(1, 0, 16'h0, 16'h0, 2'b00, 0);
      chk_all("reset", 0, 0, 0, 3'd0, 0);
      step(0, 0, 16'h0, 16'h0, 2'b00, 0);
      chk_all("idle", 0, 0, 0, 3'd0, 0);

      // ZERO mode run: saturates at 4, done only on the 4th
      for (int i = 0; i < 6; i++) begin
         step(0, 1, 16'h0000, 16'h5555, 2'b11, 0);
         chk_all($sformatf("zero_run%0d", i), 1, 1, 1, exp_cnt[i], exp_dn[i]);
      end
      step(0, 0, 16'h0001, 16'h0, 2'b11, 0);
      chk_all("gap_after_lock", 0, 1, 1, 3'd4, 0);

      // EQ sequence after clear
      step(0, 0, 16'h0, 16'h0, 2'b00, 1);
      chk("clr_idle.run_cnt", 32'(run_cnt), 32'd0);
      step(0, 1, 16'h1234, 16'h1234, 2'b00, 0);
      chk_all("eq0", 1, 0, 1, 3'd1, 0);
      step(0, 1, 16'h1234, 16'h1234, 2'b00, 0);
      chk_all("eq1", 1, 0, 1, 3'd2, 0);
      step(0, 1, 16'h1235, 16'h1234, 2'b00, 0);
      chk_all("eq2", 1, 0, 0, 3'd0, 0);
      step(0, 1, 16'h1234, 16'h1234, 2'b00, 0);
      chk_all("eq3", 1, 0, 1, 3'd1, 0);

      // LT/GT sign sensitivity; clr on the same cycle keeps the count at 0
      step(0, 1, 16'hFFFF, 16'h0001, 2'b01, 1);
      chk_all("lt_ffff_1", 1, 0, sgn, 3'd0, 0);
      step(0, 1, 16'h8000, 16'h7FFF, 2'b10, 1);
      chk_all("gt_8000_7fff", 1, 0, !sgn, 3'd0, 0);
      step(0, 1, 16'h0005, 16'h0005, 2'b01, 1);
      chk_all("lt_equal", 1, 0, 0, 3'd0, 0);
      step(0, 1, 16'h0002, 16'h0001, 2'b10, 1);
      chk_all("gt_2_1", 1, 0, 1, 3'd0, 0);
      step(0, 1, 16'h0001, 16'h0000, 2'b11, 1);
      chk_all("zero_lsb", 1, 0, 0, 3'd0, 0);

      // clr with a hit at run_cnt=3, then four hits to done
      for (int i = 0; i < 3; i++) step(0, 1, 16'h0, 16'h0, 2'b11, 0);
      chk("pre_clr.run_cnt", 32'(run_cnt), 32'd3);
      step(0, 1, 16'h0, 16'h0, 2'b11, 1);
      chk_all("clr_hit", 1, 1, 1, 3'd0, 0);
      for (int i = 0; i < 4; i++) begin
         step(0, 1, 16'h0, 16'h0, 2'b11, 0);
         chk_all($sformatf("post_clr%0d", i), 1, 1, 1, 3'(i + 1), (i == 3));
      end
      step(0, 1, 16'h0, 16'h0, 2'b11, 0);
      chk_all("lock_hit", 1, 1, 1, 3'd4, 0);
      step(0, 1, 16'h0003, 16'h0, 2'b11, 0);
      chk_all("lock_miss", 1, 0, 0, 3'd0, 0);

      // mode changes keep history, gaps hold the count, reset discards it
      step(0, 1, 16'h0007, 16'h0007, 2'b00, 0);
      chk_all("mix0", 1, 0, 1, 3'd1, 0);
      step(0, 0, 16'h0000, 16'h0001, 2'b00, 0);
      chk_all("mix_gap", 0, 0, 1, 3'd1, 0);
      step(0, 1, 16'h0009, 16'h0003, 2'b10, 0);
      chk_all("mix1", 1, 0, 1, 3'd2, 0);
      step(0, 1, 16'h0000, 16'h0003, 2'b11, 0);
      chk_all("mix2", 1, 1, 1, 3'd3, 0);
      step(1, 1, 16'h0000, 16'h0000, 2'b11, 0);
      chk_all("rst_mid_run", 0, 0, 0, 3'd0, 0);
      step(0, 1, 16'h0000, 16'h0000, 2'b11, 0);
      chk_all("after_rst", 1, 1, 1, 3'd1, 0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
